// File: rtl/lock_group_ctrl.sv
// lock_group_ctrl
//   Write-request front end for a four-register bank guarded by two sticky locks.
//   Registers 0-1 are guarded by lock1 and registers 2-3 by lock2. Writing
//   address 4 sets lock bits. The only way to clear a lock other than rst is
//   the optional two-key unlock sequence on address 5.
//
//   Build option: define LOCK_UNLOCK_EN to include the unlock FSM, which uses
//   KEY1, KEY2 and TIMEOUT. Without it, address 5 is rejected like any other
//   invalid address, and req_ready is tied high.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   request accepted when req_valid && req_ready
//   req_addr    0-3 bank register, 4 lock command, 5 unlock key, 6-7 invalid
//   req_wdata   request data
//   lock1       lock for bank registers 0-1
//   lock2       lock for bank registers 2-3
//   bank_we     one-hot bank write strobe, one cycle after acceptance
//   bank_wdata  bank write data, holds its last written value
//   err         one-cycle pulse for any rejected request or unlock timeout
module lock_group_ctrl #(
  parameter logic [31:0] KEY1    = 32'hC0DE_0001,
  parameter logic [31:0] KEY2    = 32'hC0DE_0002,
  parameter int          TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        lock1,
  output logic        lock2,
  output logic [3:0]  bank_we,
  output logic [31:0] bank_wdata,
  output logic        err
);

  logic accept;
  logic bank_hit;
  logic bank_locked;
  logic lock_cmd;
  logic key_cmd;
  logic bad_addr;
  logic unlock_now;
  logic fsm_err;

  assign accept      = req_valid && req_ready;
  assign bank_hit    = accept && !req_addr[2];
  // Address bit 1 selects the register pair, and therefore the lock that governs it.
  assign bank_locked = req_addr[1] ? lock2 : lock1;
  assign lock_cmd    = accept && (req_addr == 3'd4);
  assign key_cmd     = accept && (req_addr == 3'd5);
  assign bad_addr    = accept && (req_addr[2:1] == 2'b11);

`ifdef LOCK_UNLOCK_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_UNLOCK = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] counter;
  logic [7:0] counter_next;

  assign req_ready  = (state != ST_UNLOCK);
  assign unlock_now = (state == ST_UNLOCK);

  // Unlock sequence. While ARMED, the counter holds the number of cycles still
  // allowed for KEY2. A cycle that starts with the counter at 1 and carries no
  // key write is the last one allowed, so the FSM times out at that edge.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    fsm_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_cmd) begin
          if (req_wdata == KEY1) begin
            state_next   = ST_ARMED;
            counter_next = TIMEOUT[7:0];
          end else begin
            fsm_err = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (key_cmd) begin
          counter_next = 8'd0;
          if ((req_wdata == KEY2) && (counter != 8'd0)) begin
            state_next = ST_UNLOCK;
          end else begin
            state_next = ST_IDLE;
            fsm_err    = 1'b1;
          end
        end else if (counter <= 8'd1) begin
          state_next   = ST_IDLE;
          counter_next = 8'd0;
          fsm_err      = 1'b1;
        end else begin
          counter_next = counter - 8'd1;
        end
      end
      ST_UNLOCK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= 8'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end
`else
  logic unused_cfg;

  assign req_ready  = 1'b1;
  assign unlock_now = 1'b0;
  assign fsm_err    = key_cmd;
  assign unused_cfg = ^{KEY1, KEY2, TIMEOUT[7:0]};
`endif

  // Bank strobes, locks and the error pulse. Every error source is ORed into
  // one register, so simultaneous causes give a single pulse. A lock cannot be
  // set and cleared at the same edge because requests are stalled during UNLOCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock1      <= 1'b0;
      lock2      <= 1'b0;
      bank_we    <= 4'b0000;
      bank_wdata <= 32'd0;
      err        <= 1'b0;
    end else begin
      bank_we <= 4'b0000;
      err     <= bad_addr || fsm_err || (bank_hit && bank_locked);
      if (bank_hit && !bank_locked) begin
        bank_we    <= 4'b0001 << req_addr[1:0];
        bank_wdata <= req_wdata;
      end
      if (unlock_now) begin
        lock1 <= 1'b0;
        lock2 <= 1'b0;
      end else if (lock_cmd) begin
        lock1 <= lock1 | req_wdata[0];
        lock2 <= lock2 | req_wdata[1];
      end
    end
  end

endmodule

// File: tb/tb_lock_group_ctrl.sv
// Testbench for lock_group_ctrl
//   Directed vectors. Each stimulus cycle pushes its hand-computed expected
//   outputs into a scoreboard queue. A monitor pops that queue on every falling
//   edge and compares the entry against the DUT outputs.
module tb_lock_group_ctrl;

  localparam logic [31:0] K1 = 32'hC0DE_0001;
  localparam logic [31:0] K2 = 32'hC0DE_0002;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        lock1;
  logic        lock2;
  logic [3:0]  bank_we;
  logic [31:0] bank_wdata;
  logic        err;

  typedef struct {
    string       name;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        e;
    logic        l1;
    logic        l2;
    logic        rdy;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] expData = 32'd0;
  logic        expL1   = 1'b0;
  logic        expL2   = 1'b0;

  lock_group_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .lock1      (lock1),
    .lock2      (lock2),
    .bank_we    (bank_we),
    .bank_wdata (bank_wdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic applyStimulus(input string name, input bit r, input bit v,
                               input logic [2:0] a, input logic [31:0] d,
                               input logic [3:0] we, input bit e, input bit rdy);
    exp_t x;
    rst       = r;
    req_valid = v;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    x.name = name;
    x.we   = we;
    x.wd   = expData;
    x.e    = e;
    x.l1   = expL1;
    x.l2   = expL2;
    x.rdy  = rdy;
    sbq.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) applyStimulus(name, 0, 0, 3'd0, 32'd0, 4'b0000, 0, 1);
  endtask

  task automatic checkOutput(input exp_t x);
    checks++;
    if (bank_we !== x.we || bank_wdata !== x.wd || err !== x.e ||
        lock1 !== x.l1 || lock2 !== x.l2 || req_ready !== x.rdy) begin
      errors++;
      $display("[TB] FAIL %s: got we=%b wd=%h err=%b l1=%b l2=%b rdy=%b, want we=%b wd=%h err=%b l1=%b l2=%b rdy=%b",
               x.name, bank_we, bank_wdata, err, lock1, lock2, req_ready,
               x.we, x.wd, x.e, x.l1, x.l2, x.rdy);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 3'd0; req_wdata = 32'd0;
    @(negedge clk);

    applyStimulus("reset", 1, 0, 3'd0, 32'd0, 4'b0000, 0, 1);

    expData = 32'h1234_5678;
    applyStimulus("wr_addr2", 0, 1, 3'd2, 32'h1234_5678, 4'b0100, 0, 1);
    expData = 32'hA5A5_0000;
    applyStimulus("wr_addr0", 0, 1, 3'd0, 32'hA5A5_0000, 4'b0001, 0, 1);
    expL2 = 1'b1;
    applyStimulus("lock2_set", 0, 1, 3'd4, 32'h0000_0002, 4'b0000, 0, 1);
    applyStimulus("wr_addr3_locked", 0, 1, 3'd3, 32'h0000_DEAD, 4'b0000, 1, 1);
    applyStimulus("wr_addr2_locked", 0, 1, 3'd2, 32'h0000_BEEF, 4'b0000, 1, 1);
    expData = 32'h0000_1111;
    applyStimulus("wr_addr0_open", 0, 1, 3'd0, 32'h0000_1111, 4'b0001, 0, 1);
    expData = 32'h0000_2222;
    applyStimulus("wr_addr1_open", 0, 1, 3'd1, 32'h0000_2222, 4'b0010, 0, 1);
    applyStimulus("lock_sticky", 0, 1, 3'd4, 32'h0000_0000, 4'b0000, 0, 1);
    applyStimulus("addr6_invalid", 0, 1, 3'd6, 32'hFFFF_FFFF, 4'b0000, 1, 1);
    applyStimulus("addr7_invalid", 0, 1, 3'd7, 32'h0000_0001, 4'b0000, 1, 1);
    idle("idle_after_err", 1);
    expL1 = 1'b1;
    applyStimulus("lock1_set", 0, 1, 3'd4, 32'h0000_0001, 4'b0000, 0, 1);
    applyStimulus("wr_addr1_locked", 0, 1, 3'd1, 32'h0000_3333, 4'b0000, 1, 1);

`ifdef LOCK_UNLOCK_EN
    applyStimulus("key1_arm", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    idle("armed_wait", 3);
    applyStimulus("key2_unlock", 0, 1, 3'd5, K2, 4'b0000, 0, 0);
    expL1 = 1'b0; expL2 = 1'b0;
    applyStimulus("req_during_unlock", 0, 1, 3'd0, 32'h0000_5555, 4'b0000, 0, 1);
    expData = 32'h0000_4444;
    applyStimulus("wr_after_unlock", 0, 1, 3'd0, 32'h0000_4444, 4'b0001, 0, 1);

    expL1 = 1'b1; expL2 = 1'b1;
    applyStimulus("lock_both", 0, 1, 3'd4, 32'h0000_0003, 4'b0000, 0, 1);
    applyStimulus("key1_timeout", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    idle("timeout_wait", 7);
    applyStimulus("timeout_err", 0, 0, 3'd0, 32'd0, 4'b0000, 1, 1);
    idle("timeout_single", 1);
    applyStimulus("key2_in_idle", 0, 1, 3'd5, K2, 4'b0000, 1, 1);

    applyStimulus("key1_wrong", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    applyStimulus("wrong_key", 0, 1, 3'd5, 32'h0000_0000, 4'b0000, 1, 1);
    applyStimulus("key2_after_wrong", 0, 1, 3'd5, K2, 4'b0000, 1, 1);

    applyStimulus("key1_merge", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    idle("merge_wait", 7);
    applyStimulus("merge_err", 0, 1, 3'd0, 32'h0000_9999, 4'b0000, 1, 1);
    idle("merge_single", 1);

    applyStimulus("key1_rst", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    expL1 = 1'b0; expL2 = 1'b0; expData = 32'd0;
    applyStimulus("rst_armed", 1, 1, 3'd0, 32'h0000_8888, 4'b0000, 0, 1);
    applyStimulus("key2_after_rst", 0, 1, 3'd5, K2, 4'b0000, 1, 1);

    expL1 = 1'b1; expL2 = 1'b1;
    applyStimulus("lock_both2", 0, 1, 3'd4, 32'h0000_0003, 4'b0000, 0, 1);
    applyStimulus("key1_late", 0, 1, 3'd5, K1, 4'b0000, 0, 1);
    applyStimulus("armed_lock_cmd", 0, 1, 3'd4, 32'h0000_0000, 4'b0000, 0, 1);
    idle("late_wait", 6);
    applyStimulus("key2_last_cycle", 0, 1, 3'd5, K2, 4'b0000, 0, 0);
    expL1 = 1'b0; expL2 = 1'b0;
    idle("unlock_done", 1);
    expData = 32'h0000_ABCD;
    applyStimulus("wr_addr3_open", 0, 1, 3'd3, 32'h0000_ABCD, 4'b1000, 0, 1);
`else
    applyStimulus("key1_no_fsm", 0, 1, 3'd5, K1, 4'b0000, 1, 1);
    applyStimulus("key2_no_fsm", 0, 1, 3'd5, K2, 4'b0000, 1, 1);
    idle("idle_no_fsm", 1);
    expL1 = 1'b0; expL2 = 1'b0; expData = 32'd0;
    applyStimulus("rst_with_req", 1, 1, 3'd2, 32'h0000_8888, 4'b0000, 0, 1);
    expData = 32'h0000_7777;
    applyStimulus("wr_addr3_after_rst", 0, 1, 3'd3, 32'h0000_7777, 4'b1000, 0, 1);
    applyStimulus("key1_after_rst", 0, 1, 3'd5, K1, 4'b0000, 1, 1);
`endif

    @(posedge clk);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_group_ctrl.md
LOCK_GROUP_CTRL -- requirements
Module: lock_group_ctrl

Interface
REQ-001 SHALL have parameter KEY1, default 32'hC0DE_0001, first unlock key.
REQ-002 SHALL have parameter KEY2, default 32'hC0DE_0002, second unlock key.
REQ-003 SHALL have parameter TIMEOUT, default 8, max cycles allowed between KEY1 and KEY2 (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  write request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_addr  input  3  0-3 bank register, 4 lock command, 5 unlock key, 6-7 invalid.
REQ-009 SHALL have port req_wdata  input  32  request data.
REQ-010 SHALL have port lock1  output  1  lock for bank registers 0-1.
REQ-011 SHALL have port lock2  output  1  lock for bank registers 2-3.
REQ-012 SHALL have port bank_we  output  4  one-hot register-bank write strobe.
REQ-013 SHALL have port bank_wdata  output  32  register-bank write data.
REQ-014 SHALL have port err  output  1  one-cycle pulse on any rejected request.

Function
REQ-015 Accepted write to addr 0-3 SHALL assert bank_we[addr] with bank_wdata=req_wdata exactly 1 cycle later, if the governing lock (registered value in the acceptance cycle) is 0.
REQ-016 Accepted write to a locked register SHALL produce bank_we=0 and err=1 one cycle later.
REQ-017 bank_we SHALL be 0 in every cycle not covered by REQ-015; bank_wdata holds its last value.
REQ-018 Accepted write to addr 4 SHALL set lock1 |= wdata[0] and lock2 |= wdata[1] on the next edge; locks are sticky, and writing 0 never clears them.
REQ-019 A lock set at edge N SHALL block bank writes accepted at edge N or later.
REQ-020 Addr 6-7 SHALL produce err one cycle later and no other effect.
REQ-021 Unlock FSM SHALL have states IDLE, ARMED, UNLOCK.
REQ-022 IDLE: addr-5 write of KEY1 -> ARMED with counter=TIMEOUT; addr-5 write of any other value -> err, stay IDLE.
REQ-023 ARMED: counter decrements each cycle without a KEY2 write.
REQ-024 ARMED: addr-5 write of KEY2 while counter>0 -> UNLOCK.
REQ-025 ARMED: addr-5 write of a wrong value -> IDLE with err.
REQ-026 ARMED: counter reaching 0 -> IDLE with err.
REQ-027 ARMED: addr 0-4 requests SHALL be processed normally.
REQ-028 UNLOCK SHALL last exactly 1 cycle, clear lock1 and lock2, hold req_ready=0, then -> IDLE.
REQ-029 req_ready SHALL be 1 in every state except UNLOCK.
REQ-030 Only one err pulse SHALL be issued per cycle; simultaneous causes (timeout plus rejected write) merge into one pulse.

Reset
REQ-031 On rst: lock1=0, lock2=0, bank_we=0, bank_wdata=0, err=0, FSM=IDLE, counter=0, req_ready=1.
REQ-032 rst mid-sequence (ARMED/UNLOCK) SHALL abandon the sequence; requests in the rst cycle are ignored, and any pending bank_we from the prior cycle is suppressed.

Configuration
REQ-033 Macro LOCK_UNLOCK_EN defined: unlock FSM and KEY1/KEY2/TIMEOUT logic present per REQ-021..REQ-028.
REQ-034 LOCK_UNLOCK_EN undefined: no FSM; req_ready tied 1; addr 5 treated as invalid (err); locks clear only on rst.

Verification
REQ-035 After rst, write addr 2 data 32'h1234_5678 -> next cycle bank_we=4'b0100, bank_wdata=32'h1234_5678, err=0.
REQ-036 Write addr 4 data 32'h2, then write addr 3 -> lock2=1, bank_we=0, err=1; a following write to addr 0 succeeds with bank_we=4'b0001.
REQ-037 Locks both set; KEY1, 3 idle cycles, KEY2 -> one UNLOCK cycle with req_ready=0, then lock1=lock2=0.
REQ-038 KEY1 followed by 8 idle cycles (TIMEOUT=8) -> FSM returns to IDLE with a single err pulse; a later KEY2 -> err, locks unchanged.
REQ-039 KEY1 then addr-5 write 32'h0 -> err, IDLE; KEY1, rst while ARMED, then KEY2 -> err, locks remain reset values.
REQ-040 Build without LOCK_UNLOCK_EN: KEY1 then KEY2 -> err on each, locks unchanged, req_ready constant 1.
